// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM driver:
// command encoding, counter width and forward/backward target decode.
package servo_pkg;

  // {forward, backward} command encodings
  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_FWD  = 2'b10;
  localparam logic [1:0] CMD_BWD  = 2'b01;

  localparam int unsigned CLK_PER_US_DIV = 1_000_000;

  // Bit width of the microsecond counter and width registers.
  function automatic int unsigned us_w(input int unsigned frame_us);
    return (frame_us > 1) ? $clog2(frame_us) : 1;
  endfunction

  // Pulse width in us requested by a {forward, backward} command pair.
  function automatic int unsigned target_us(input logic [1:0]  cmd,
                                            input int unsigned neutral_us,
                                            input int unsigned span_us);
    int unsigned t;
    case (cmd)
      CMD_FWD:  t = neutral_us + span_us;
      CMD_BWD:  t = neutral_us - span_us;
      CMD_STOP: t = neutral_us;
      default:  t = neutral_us;  // both asserted means stop
    endcase
    return t;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: target decode, per-frame slew-limited width register,
// pulse comparator and the registered pwm/ramping outputs.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned US_W       = 15,
  parameter int unsigned NEUTRAL_US = 1500,
  parameter int unsigned SPAN_US    = 500,
  parameter int unsigned RAMP_US    = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable_i,
  input  logic            forward_i,
  input  logic            backward_i,
  input  logic            wrap_tick_i,
  input  logic [US_W-1:0] us_cnt_i,
  output logic            pwm_o,
  output logic            ramping_o
);

  localparam int unsigned EW = US_W + 1;
  localparam logic [EW-1:0] RampX = EW'(RAMP_US);

  logic [US_W-1:0] target;
  logic [US_W-1:0] width_q, width_d;
  logic            ramping_q, ramping_d;
  logic            pwm_q, pwm_d;
  logic [EW-1:0]   tgt_x, wid_x, step_x;

  assign target = US_W'(target_us({forward_i, backward_i}, NEUTRAL_US, SPAN_US));

  always_comb begin
    // One spare bit keeps the distance and step arithmetic from wrapping
    tgt_x  = {1'b0, target};
    wid_x  = {1'b0, width_q};
    step_x = wid_x;
    if (RAMP_US == 0) begin
      step_x = tgt_x;
    end else if (tgt_x > wid_x) begin
      step_x = ((tgt_x - wid_x) <= RampX) ? tgt_x : (wid_x + RampX);
    end else begin
      step_x = ((wid_x - tgt_x) <= RampX) ? tgt_x : (wid_x - RampX);
    end

    width_d   = width_q;
    ramping_d = ramping_q;
    if (wrap_tick_i) begin
      width_d   = step_x[US_W-1:0];
      ramping_d = (step_x[US_W-1:0] != target);
    end

    pwm_d = enable_i & (us_cnt_i < width_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q   <= US_W'(NEUTRAL_US);
      ramping_q <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      width_q   <= width_d;
      ramping_q <= ramping_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign ramping_o = ramping_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM driver: shared microsecond timebase and
// frame counter feeding NUM_CH independent slew-limited channels.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned FRAME_US   = 20000,
  parameter int unsigned NEUTRAL_US = 1500,
  parameter int unsigned SPAN_US    = 500,
  parameter int unsigned RAMP_US    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] forward,
  input  logic [NUM_CH-1:0] backward,
  output logic [NUM_CH-1:0] pwm,
  output logic              frame_start,
  output logic [NUM_CH-1:0] ramping
);

  localparam int unsigned US_W = us_w(FRAME_US);
  localparam int unsigned DIV  = CLK_HZ / CLK_PER_US_DIV;
  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;

  if (NEUTRAL_US + SPAN_US >= FRAME_US) begin : g_bad_frame
    $error("servo_pwm_multi: NEUTRAL_US + SPAN_US must be below FRAME_US");
  end
  if (SPAN_US > NEUTRAL_US) begin : g_bad_span
    $error("servo_pwm_multi: SPAN_US must not exceed NEUTRAL_US");
  end
  if ((CLK_HZ % CLK_PER_US_DIV != 0) || (DIV == 0)) begin : g_bad_clk
    $error("servo_pwm_multi: CLK_HZ must be a non-zero multiple of 1 MHz");
  end

  logic [PW-1:0]   presc_q, presc_d;
  logic [US_W-1:0] us_cnt_q, us_cnt_d;
  logic            frame_start_q, frame_start_d;
  logic            us_tick;
  logic            wrap_tick;

  always_comb begin
    us_tick   = (presc_q == PW'(DIV - 1));
    // Last tick of the frame: channels sample commands and step widths here
    wrap_tick = us_tick && (us_cnt_q == US_W'(FRAME_US - 1));

    presc_d = us_tick ? '0 : (presc_q + PW'(1));

    us_cnt_d = us_cnt_q;
    if (us_tick) begin
      us_cnt_d = wrap_tick ? '0 : (us_cnt_q + US_W'(1));
    end

    frame_start_d = wrap_tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      us_cnt_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      us_cnt_q      <= us_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_channel #(
      .US_W       (US_W),
      .NEUTRAL_US (NEUTRAL_US),
      .SPAN_US    (SPAN_US),
      .RAMP_US    (RAMP_US)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable_i    (enable),
      .forward_i   (forward[i]),
      .backward_i  (backward[i]),
      .wrap_tick_i (wrap_tick),
      .us_cnt_i    (us_cnt_q),
      .pwm_o       (pwm[i]),
      .ramping_o   (ramping[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: per-frame expected pulse lengths and
// ramping flags from an arithmetic reference model, checked by a frame monitor.
module tb_servo_pwm_multi;

  localparam int NCH        = 2;
  localparam int CLK_HZ     = 2_000_000;
  localparam int FRAME_US   = 300;
  localparam int NEUTRAL_US = 150;
  localparam int SPAN_US    = 100;
  localparam int RAMP_US    = 20;
  localparam int DIV        = CLK_HZ / 1_000_000;
  localparam int FRAME_CLK  = FRAME_US * DIV;
  localparam int GLITCH_CLK = 50 * DIV;
  localparam int TAIL_CLK   = (FRAME_US - 20) * DIV;
  localparam int ABORT_CLK  = 60;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [NCH-1:0] forward = '0;
  logic [NCH-1:0] backward = '0;
  logic [NCH-1:0] pwm;
  logic           frame_start;
  logic [NCH-1:0] ramping;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH     (NCH),
    .CLK_HZ     (CLK_HZ),
    .FRAME_US   (FRAME_US),
    .NEUTRAL_US (NEUTRAL_US),
    .SPAN_US    (SPAN_US),
    .RAMP_US    (RAMP_US)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .forward     (forward),
    .backward    (backward),
    .pwm         (pwm),
    .frame_start (frame_start),
    .ramping     (ramping)
  );

  typedef struct packed {
    logic [NCH-1:0]       ramp;
    logic [NCH-1:0][15:0] pulse;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   frames_pushed = 0;
  int   frames_checked = 0;

  int   mdl_w[NCH];
  bit   mdl_r[NCH];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_target(input bit f, input bit b);
    if (f && !b) return NEUTRAL_US + SPAN_US;
    if (b && !f) return NEUTRAL_US - SPAN_US;
    return NEUTRAL_US;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mdl_w[c] = NEUTRAL_US;
      mdl_r[c] = 1'b0;
    end
  endtask

  task automatic model_wrap(input logic [NCH-1:0] f, input logic [NCH-1:0] b);
    int t, d;
    for (int c = 0; c < NCH; c++) begin
      t = ref_target(f[c], b[c]);
      d = t - mdl_w[c];
      if (RAMP_US == 0 || (d <= RAMP_US && d >= -RAMP_US)) mdl_w[c] = t;
      else mdl_w[c] = mdl_w[c] + ((d > 0) ? RAMP_US : -RAMP_US);
      mdl_r[c] = (mdl_w[c] != t);
    end
  endtask

  task automatic do_reset_midframe();
    check("pre_reset_pwm_high", int'(pwm), (1 << NCH) - 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm), 0);
    check("async_reset_frame_start", int'(frame_start), 0);
    check("async_reset_ramping", int'(ramping), 0);
    exp_q.delete();
    frames_pushed--;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One frame of stimulus; f/b/en take effect at the tail and govern the next frame.
  task automatic run_frame(input logic [NCH-1:0] f, input logic [NCH-1:0] b, input logic en,
                           input int abort_at);
    exp_t e;
    for (int c = 0; c < NCH; c++) begin
      e.pulse[c] = enable ? 16'(mdl_w[c] * DIV) : 16'd0;
      e.ramp[c]  = mdl_r[c];
    end
    exp_q.push_back(e);
    frames_pushed++;
    for (int j = 1; j <= FRAME_CLK; j++) begin
      @(negedge clk);
      if (j == abort_at) begin
        do_reset_midframe();
        return;
      end
      if (j == GLITCH_CLK) begin
        forward  = NCH'($urandom_range(0, (1 << NCH) - 1));
        backward = NCH'($urandom_range(0, (1 << NCH) - 1));
      end
      if (j == TAIL_CLK) begin
        forward  = f;
        backward = b;
        enable   = en;
      end
    end
    model_wrap(f, b);
  endtask

  // Monitor: accumulates pulse lengths per frame, checks at each frame_start.
  initial begin
    int             since;
    int             cnt[NCH];
    logic [NCH-1:0] rm;
    exp_t           e;
    since = 0;
    rm    = '0;
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        since = 0;
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        continue;
      end
      since++;
      for (int c = 0; c < NCH; c++) cnt[c] += int'(pwm[c]);
      if (since == 1) rm = ramping;
      if (frame_start) begin
        check("frame_period", since, FRAME_CLK);
        if (exp_q.size() == 0) begin
          check("scoreboard_has_entry", 0, 1);
        end else begin
          e = exp_q.pop_front();
          for (int c = 0; c < NCH; c++) begin
            check($sformatf("pulse_clk_ch%0d_f%0d", c, frames_checked), cnt[c], int'(e.pulse[c]));
            check($sformatf("ramping_ch%0d_f%0d", c, frames_checked), int'(rm[c]), int'(e.ramp[c]));
          end
          frames_checked++;
        end
        since = 0;
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
      end else if (since > FRAME_CLK + 8) begin
        check("frame_start_timeout", since, FRAME_CLK);
        since = 0;
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
      end
    end
  end

  initial begin
    logic [NCH-1:0] f, b;
    logic           en;
    model_reset();
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_ramping", int'(ramping), 0);
    #2 rst_n = 1'b1;

    repeat (2)  run_frame(2'b00, 2'b00, 1'b1, 0);  // neutral on both
    repeat (7)  run_frame(2'b01, 2'b00, 1'b1, 0);  // ch0 up to full forward
    repeat (12) run_frame(2'b00, 2'b01, 1'b1, 0);  // ch0 reverses to full backward
    repeat (7)  run_frame(2'b01, 2'b01, 1'b1, 0);  // both bits: back to neutral
    repeat (3)  run_frame(2'b01, 2'b00, 1'b0, 0);  // ramp up while disabled
    run_frame(2'b01, 2'b00, 1'b1, 0);

    f = '0;
    b = '0;
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        f = NCH'($urandom_range(0, (1 << NCH) - 1));
        b = NCH'($urandom_range(0, (1 << NCH) - 1));
      end
      en = ($urandom_range(0, 7) != 0);
      run_frame(f, b, en, 0);
    end

    repeat (2) run_frame(2'b01, 2'b00, 1'b1, 0);
    run_frame(2'b01, 2'b00, 1'b1, ABORT_CLK);       // reset inside the pulse
    repeat (3) run_frame(2'b10, 2'b00, 1'b1, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("frames_checked", frames_checked, frames_pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Parametrised multi-channel successor to the single-channel forward/backward servo driver. Each channel turns a forward/backward command pair into a standard hobby-servo PWM pulse (neutral ± span) in a fixed-period frame. Commands are slew-limited (pulse-width ramp per frame) to avoid current spikes on direction reversal. Sits between the robot control logic and the motor output pins; all channels share one frame timer.

Parameters:
NUM_CH, 2, number of independent servo channels
CLK_HZ, 50_000_000, input clock frequency in Hz; must be an integer multiple of 1_000_000
FRAME_US, 20000, PWM frame period in microseconds
NEUTRAL_US, 1500, pulse width for stop, in us
SPAN_US, 500, deviation from neutral at full forward (+) / backward (-), in us
RAMP_US, 20, maximum pulse-width change per frame, in us; 0 means no ramp (jump to target)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  global output enable; low forces all pwm low
forward  in  NUM_CH  per-channel forward command, bit i = channel i
backward  in  NUM_CH  per-channel backward command
pwm  out  NUM_CH  per-channel servo pulse, registered
frame_start  out  1  one-cycle pulse at start of each frame
ramping  out  NUM_CH  bit i high while channel i width != its target

Behaviour:
- Reset (rst_n low, async): pwm=0, frame_start=0, ramping=0, prescaler=0, us_cnt=0, every width register=NEUTRAL_US.
- Prescaler counts 0..CLK_HZ/1e6-1; us_tick asserts one cycle when it wraps. us_cnt increments on us_tick, wraps FRAME_US-1 -> 0.
- frame_start: registered, high for exactly one clk cycle following the us_tick on which us_cnt wraps to 0. First frame_start occurs FRAME_US us after reset release.
- Target per channel, decoded combinationally from forward/backward: 10 -> NEUTRAL_US+SPAN_US; 01 -> NEUTRAL_US-SPAN_US; 00 or 11 -> NEUTRAL_US (simultaneous = stop).
- Commands sampled only at the wrap us_tick; changes mid-frame never alter the current pulse.
- Width update at the wrap us_tick: if |target-width| <= RAMP_US or RAMP_US=0, width<=target; else width moves RAMP_US toward target. Reversal full-fwd -> full-bwd at defaults takes 50 frames, passing through neutral.
- pwm[i] <= enable & (us_cnt < width[i]), registered: one clk latency from us_cnt. Pulse width exactly width[i] us, ±1 clk.
- enable low: pwm forced 0 next cycle; width registers and ramps continue updating (output resumes at ramped width). enable rising mid-frame: pwm follows comparison immediately (may yield truncated pulse; accepted).
- ramping[i] = (width[i] != target[i]), registered with width.
- Widths: us_cnt and widths use $clog2(FRAME_US) bits; arithmetic in one extra bit, no wrap. Elaboration-time assertions: NEUTRAL_US+SPAN_US < FRAME_US, SPAN_US <= NEUTRAL_US, CLK_HZ % 1e6 == 0.
- Reset mid-frame: all state returns to reset values immediately; pwm drops low asynchronously.

Decomposition:
- Package servo_pkg: US_W = $clog2(FRAME_US) function/constant, command encoding localparams (CMD_STOP, CMD_FWD, CMD_BWD), target-width decode function.
- Top holds prescaler, us_cnt, frame_start (shared timebase).
- One sub-module servo_channel, instantiated NUM_CH times via generate: target decode, ramp register, comparator, pwm/ramping flops.

Test Plan:
(use CLK_HZ=2_000_000, NUM_CH=2, defaults otherwise)
- Reset, enable=1, all commands 00 -> both pwm high 1500 us (3000 clk) per 20000 us frame; frame_start every 40000 clk; ramping=0.
- ch0 forward=1 from neutral -> ch0 widths 1520,1540,...,2000 on successive frames, ramping[0] high for 25 frames then low; ch1 unchanged at 1500.
- ch0 at 2000, switch to backward -> width decreases 20 us/frame to 1000 after 50 frames; forward=backward=1 at 1000 -> ramps back to 1500 in 25 frames.
- Toggle forward mid-frame (us_cnt=500) and back before wrap -> no width change next frame, pulse lengths unaffected.
- enable=0 for 3 frames while ch0 ramps up -> pwm flat 0, ramping[0] still high, width advances 60 us; enable=1 -> pulse resumes at advanced width.
- Assert rst_n low at us_cnt=1000 with ch0 at 1800 -> pwm=0 same cycle; after release first pulse is 1500 us, frame_start after 20000 us.
